// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_if
//  Purpose  : Start/busy/done handshake and operand/result bundle for
//             serial_adder.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial WIDTH-bit adder, one full-adder cell plus carry
//             flop, LSB first, with start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_ps;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic w_s;
    logic w_carry;

    assign w_s     = r_ra[0] ^ r_rb[0] ^ r_c;
    assign w_carry = (r_ra[0] & r_rb[0]) | (r_ra[0] & r_c) | (r_rb[0] & r_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_ps    <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_ra    <= bus.a;
                        r_rb    <= bus.b;
                        r_c     <= bus.cin;
                        r_ps    <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_c   <= w_carry;
                    r_ps  <= {w_s, r_ps[WIDTH-1:1]};
                    r_ra  <= r_ra >> 1;
                    r_rb  <= r_rb >> 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST_BIT) begin
                        // On the MSB step r_c is exactly the carry into the MSB.
                        r_sum   <= {w_s, r_ps[WIDTH-1:1]};
                        r_cout  <= w_carry;
                        r_ovf   <= r_c ^ w_carry;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule
`default_nettype wire
